inst_mem_responder: RTL and testbench
=====================================

Name: inst_mem_responder

Overview:
- Responder end of the fetch interface: accepts one instruction-fetch request (PC address) from the PC/fetch initiator and returns one 32-bit instruction.
- Reads a 64-bit-wide synchronous instruction memory port and selects the addressed 32-bit half.
- Sits between the PC stage and the decode stage; handles misalignment and range faults and trap-redirect flushes.

Parameters:
- MEM_BASE, 64'h8000_0000, byte base address of instruction memory
- MEM_DEPTH_LOG2, 16, log2 of the number of 64-bit memory words
- LATENCY, 0, extra wait cycles inserted after the memory read data is captured (0..15)

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-low; clears state on the rising clk edge while low
- req_valid  input  1  fetch request valid
- req_ready  output  1  responder can accept a request
- req_addr  input  `XLEN  fetch byte address (pc_out)
- flush  input  1  trap or branch redirect; discard any in-flight fetch
- resp_valid  output  1  instruction response valid
- resp_ready  input  1  decode stage accepts the response
- resp_inst  output  32  fetched instruction
- resp_fault  output  2  0 = ok, 1 = misaligned, 2 = access fault
- mem_en  output  1  memory read enable (one cycle per access)
- mem_addr  output  MEM_DEPTH_LOG2  memory word index
- mem_rdata  input  64  memory data, valid the cycle after mem_en

Behaviour:
- Reset (rst low at an edge): state goes to IDLE; resp_valid=0, resp_inst=0, resp_fault=0, wait counter=0. mem_en and req_ready are combinational and are 0 while rst is low.
- FSM states: IDLE, READ, WAIT, RESP.
- IDLE:
  - req_ready = ~flush.
  - Accept = req_valid & req_ready. Latch req_addr[2] and the fault code.
  - Fault check: req_addr[1:0]!=0 → misaligned (1). Otherwise, (req_addr - MEM_BASE) >= 8<<MEM_DEPTH_LOG2 → access fault (2). Misaligned takes priority.
  - No fault: in the accept cycle, mem_en=1 and mem_addr=(req_addr-MEM_BASE)[MEM_DEPTH_LOG2+2:3]; next state READ.
  - Fault: no mem_en; next state RESP with resp_inst=0, resp_fault=code.
- READ: capture mem_rdata[63:32] if addr[2]=1, else [31:0], into resp_inst. If LATENCY=0 go to RESP, else load counter=LATENCY-1 and go to WAIT.
- WAIT: counter decrements each cycle; on 0 go to RESP.
- RESP: resp_valid=1; resp_inst and resp_fault stable until handshake. On resp_valid&resp_ready go to IDLE; req_ready returns the following cycle (no same-cycle re-accept).
- Latency, accept edge at cycle T:
  - ok response: resp_valid first high in cycle T+2+LATENCY.
  - fault response: resp_valid first high in cycle T+1.
- req_ready=0 in every state except IDLE. mem_en is high for exactly one cycle per accepted non-fault request.
- flush:
  - In READ, WAIT or RESP: next state IDLE; resp_valid drops next cycle; no response is delivered.
  - Flush wins over a simultaneous resp handshake; the response counts as not consumed.
  - Flush in IDLE blocks acceptance that cycle.
  - mem_rdata arriving after a flush is ignored.
- Address arithmetic: subtraction is modulo 2^XLEN, so addresses below MEM_BASE wrap to large values and produce an access fault.
- Reset mid-operation behaves as flush plus clearing all registers.

Decomposition:
- `XLEN, `XLEN_BUS, the fault-code constants (FETCH_OK/FETCH_MISALIGN/FETCH_ACCESS) and the FSM state encodings belong in sysconfig.v.
- No sub-module is needed. An optional small wait counter stays inline.

Test Plan:
- Reset: hold rst low for 3 cycles with req_valid=1 → req_ready=0, mem_en=0, resp_valid=0. Release → req_ready=1.
- Aligned fetch, LATENCY=0, addr 0x8000_0004, word 0 = 64'h00A00093_00000013 → mem_en at T with mem_addr=0; resp_valid at T+2; resp_inst=0x00A00093; resp_fault=0.
- LATENCY=3, addr 0x8000_0000 → resp_inst=0x00000013 at T+5. resp_ready held low 4 cycles → outputs stable; req_ready stays 0 until the cycle after the handshake.
- Addr 0x8000_0002 → no mem_en; resp_valid at T+1, resp_fault=1. Addr 0x7FFF_FFFC → resp_fault=2. Addr MEM_BASE+0x80000 (default depth) → resp_fault=2.
- Flush in READ, then flush in RESP together with resp_ready=1 → no response delivered, back to IDLE. Next fetch of 0x8000_0008 returns word 1 correctly.
- Back-to-back: 8 sequential fetches from 0x8000_0000 with resp_ready=1 → each response matches memory; exactly 8 mem_en pulses.

Source files
------------

// File: rtl/inst_mem_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package inst_mem_responder_pkg;

    // Fetch address / PC width.
    localparam int XLEN = 64;

    // Fault code returned alongside every fetch response.
    typedef enum logic [1:0] {
        FETCH_OK       = 2'd0,
        FETCH_MISALIGN = 2'd1,
        FETCH_ACCESS   = 2'd2
    } fetch_fault_e;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } fetch_state_e;

    // Misalignment outranks a range fault.
    function automatic fetch_fault_e fetch_fault(input logic misaligned, input logic out_of_range);
        if (misaligned)   return FETCH_MISALIGN;
        if (out_of_range) return FETCH_ACCESS;
        return FETCH_OK;
    endfunction

endpackage

// File: rtl/inst_mem_responder.sv
// Responder end of the fetch interface: one request in, one 32-bit
// instruction (or fault) out, backed by a 64-bit synchronous memory port.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE       = 64'h8000_0000,
    parameter int              MEM_DEPTH_LOG2 = 16,
    parameter int              LATENCY        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [XLEN-1:0]           req_addr,
    input  logic                      flush,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_inst,
    output logic [1:0]                resp_fault,
    output logic                      mem_en,
    output logic [MEM_DEPTH_LOG2-1:0] mem_addr,
    input  logic [63:0]               mem_rdata
);

    // Counter preload; WAIT spends exactly LATENCY cycles (load value down to 0).
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    fetch_state_e     state_q;
    fetch_fault_e     fault_q;
    fetch_fault_e     fault_code;
    logic             addr2_q;
    logic [31:0]      inst_q;
    logic             resp_valid_q;
    logic [3:0]       cnt_q;
    logic [XLEN-1:0]  offset;
    logic             out_of_range;
    logic             accept;
    logic             unused_offset_lo;

    // Wrapping subtraction: addresses below MEM_BASE become huge and fault.
    assign offset           = req_addr - MEM_BASE;
    assign out_of_range     = |offset[XLEN-1:MEM_DEPTH_LOG2+3];
    assign fault_code       = fetch_fault(|req_addr[1:0], out_of_range);
    assign unused_offset_lo = ^offset[2:0];

    // Flush in IDLE blocks acceptance; nothing is accepted while in reset.
    assign req_ready = rst & ~flush & (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign mem_en    = accept & (fault_code == FETCH_OK);
    assign mem_addr  = offset[MEM_DEPTH_LOG2+2:3];

    assign resp_valid = resp_valid_q;
    assign resp_inst  = inst_q;
    assign resp_fault = fault_q;

    // Fetch FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fault_q      <= FETCH_OK;
            addr2_q      <= 1'b0;
            inst_q       <= '0;
            resp_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr2_q <= req_addr[2];
                        fault_q <= fault_code;
                        if (fault_code != FETCH_OK) begin
                            inst_q       <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        inst_q <= addr2_q ? mem_rdata[63:32] : mem_rdata[31:0];
                        if (LATENCY == 0) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            cnt_q   <= LAT_M1;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Flush also lands here; the response is simply dropped.
                    if (flush || resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: two instances (LATENCY 0 and 3) against a
// behavioural fetch model and a synchronous memory model.
module tb_inst_mem_responder;
    import inst_mem_responder_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          DL2  = 16;
    localparam int          LAT0 = 0;
    localparam int          LAT1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0]        req_valid  = '0;
    logic [1:0]        flush      = '0;
    logic [1:0]        resp_ready = '0;
    logic [1:0][63:0]  req_addr   = '0;
    logic [1:0][63:0]  mem_rdata;
    wire  [1:0]        req_ready;
    wire  [1:0]        resp_valid;
    wire  [1:0]        mem_en;
    wire  [1:0][31:0]  resp_inst;
    wire  [1:0][1:0]   resp_fault;
    wire  [1:0][15:0]  mem_addr;

    int total = 0;
    int bad   = 0;
    int en_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    inst_mem_responder #(.MEM_BASE(BASE), .MEM_DEPTH_LOG2(DL2), .LATENCY(LAT0)) u_lat0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .flush(flush[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_inst(resp_inst[0]), .resp_fault(resp_fault[0]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]));

    inst_mem_responder #(.MEM_BASE(BASE), .MEM_DEPTH_LOG2(DL2), .LATENCY(LAT1)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .flush(flush[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_inst(resp_inst[1]), .resp_fault(resp_fault[1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]));

    // Memory contents as a pure function of the word index.
    function automatic logic [63:0] memword(input logic [15:0] idx);
        if (idx == 16'd0) return 64'h00A00093_00000013;
        return {32'(idx) * 32'h9E37_79B9 + 32'h1234_5677, (32'(idx) * 32'h85EB_CA6B) ^ 32'hCAFE_F00D};
    endfunction

    // Synchronous read port; garbage on idle cycles so mistimed capture shows.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] <= mem_en[k] ? memword(mem_addr[k]) : {$urandom, $urandom};
            if (rst && mem_en[k]) en_cnt[k] <= en_cnt[k] + 1;
        end
    end

    function automatic logic [1:0] exp_fault(input logic [63:0] a);
        if (a % 4 != 0) return 2'd1;
        if (a - BASE >= (64'd8 << DL2)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] a);
        logic [63:0] w;
        if (exp_fault(a) != 2'd0) return 32'd0;
        w = memword(16'((a - BASE) / 8));
        return ((a / 4) % 2 == 1) ? w[63:32] : w[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete fetch on instance k, holding resp_ready low for 'hold' cycles.
    task automatic fetch(input int k, input logic [63:0] addr, input int hold);
        int          lat = (k == 0) ? LAT0 : LAT1;
        logic [1:0]  ef  = exp_fault(addr);
        logic [31:0] ei  = exp_inst(addr);
        int          n   = 0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        #1;
        check("idle_req_ready", req_ready[k], 1);
        check("accept_mem_en", mem_en[k], ef == 2'd0);
        if (ef == 2'd0) check("mem_addr", mem_addr[k], (addr - BASE) / 8);
        do begin
            @(negedge clk);
            req_valid[k] = 1'b0;
            n++;
            #1;
            if (!resp_valid[k]) begin
                check("busy_req_ready", req_ready[k], 0);
                check("busy_mem_en", mem_en[k], 0);
            end
        end while (!resp_valid[k] && n < 40);
        check("latency", n, (ef == 2'd0) ? 2 + lat : 1);
        check("resp_inst", resp_inst[k], ei);
        check("resp_fault", resp_fault[k], ef);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid", resp_valid[k], 1);
            check("hold_inst", resp_inst[k], ei);
            check("hold_fault", resp_fault[k], ef);
            check("hold_req_ready", req_ready[k], 0);
        end
        @(negedge clk);
        resp_ready[k] = 1'b1;
        #1;
        check("hs_req_ready", req_ready[k], 0);
        check("hs_inst", resp_inst[k], ei);
        @(negedge clk);
        resp_ready[k] = 1'b0;
        #1;
        check("post_hs_valid", resp_valid[k], 0);
        check("post_hs_req_ready", req_ready[k], 1);
    endtask

    // Accept a good fetch, then flush 'at' cycles after acceptance with resp_ready=rr.
    task automatic flush_at(input int k, input logic [63:0] addr, input int at, input logic rr);
        logic seen = 1'b0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        for (int i = 0; i < at; i++) begin
            @(negedge clk);
            req_valid[k] = 1'b0;
        end
        flush[k]      = 1'b1;
        resp_ready[k] = rr;
        #1;
        check("flush_req_ready", req_ready[k], 0);
        @(negedge clk);
        flush[k]      = 1'b0;
        resp_ready[k] = 1'b0;
        #1;
        check("flush_valid", resp_valid[k], 0);
        check("flush_idle", req_ready[k], 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            seen |= resp_valid[k];
        end
        check("flush_no_resp", seen, 0);
    endtask

    initial begin
        int          snap;
        logic [63:0] a;

        // Reset held low with requests pending.
        req_valid = 2'b11;
        req_addr  = '{BASE, BASE};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                check("rst_req_ready", req_ready[k], 0);
                check("rst_mem_en", mem_en[k], 0);
                check("rst_resp_valid", resp_valid[k], 0);
            end
        end
        check("rst_inst", resp_inst[1], 0);
        check("rst_fault", resp_fault[0], 0);
        req_valid = 2'b00;
        rst       = 1'b1;
        #1;
        check("rst_release_ready0", req_ready[0], 1);
        check("rst_release_ready1", req_ready[1], 1);

        // Directed fetches and faults.
        fetch(0, 64'h8000_0004, 0);
        fetch(1, 64'h8000_0000, 4);
        fetch(0, 64'h8000_0002, 1);
        fetch(0, 64'h7FFF_FFFC, 0);
        fetch(0, BASE + 64'h8_0000, 0);
        fetch(1, BASE + 64'h7_FFFC, 2);
        fetch(1, 64'h8000_0003, 0);

        // Flushes: IDLE, READ, WAIT and RESP (with a simultaneous handshake).
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 64'h8000_0010;
        flush[0]     = 1'b1;
        #1;
        check("idle_flush_ready", req_ready[0], 0);
        check("idle_flush_mem_en", mem_en[0], 0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        #1;
        check("idle_flush_no_accept", req_ready[0], 1);
        flush_at(0, 64'h8000_0010, 1, 1'b0);
        flush_at(0, 64'h8000_0014, 2, 1'b1);
        fetch(0, 64'h8000_0008, 0);
        flush_at(1, 64'h8000_0020, 2, 1'b0);
        flush_at(1, 64'h8000_0024, 5, 1'b1);
        fetch(1, 64'h8000_000C, 1);

        // Back-to-back sequential fetches, counting memory enables.
        for (int k = 0; k < 2; k++) begin
            snap = en_cnt[k];
            for (int i = 0; i < 8; i++) fetch(k, BASE + 64'(4 * i), 0);
            check("mem_en_count", en_cnt[k] - snap, 8);
        end

        // Reset in the middle of a held response.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 64'h8000_0040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid[1] = 1'b0;
        end
        #1;
        check("mid_pre_valid", resp_valid[1], 1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", req_ready[1], 0);
        @(negedge clk);
        #1;
        check("mid_rst_valid", resp_valid[1], 0);
        check("mid_rst_inst", resp_inst[1], 0);
        rst = 1'b1;
        #1;
        check("mid_rst_release", req_ready[1], 1);

        // Randomized fetches over all address classes.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = BASE + 64'(4 * $urandom_range(0, (2 << DL2) - 1));
                2:       a = BASE + 64'(4 * $urandom_range(0, 255)) + 64'($urandom_range(1, 3));
                3:       a = BASE - 64'(4 * $urandom_range(1, 1000));
                default: a = BASE + (64'd8 << DL2) + 64'(4 * $urandom_range(0, 1000));
            endcase
            fetch(it % 2, a, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
